// File: rtl/mips_lite_pkg.sv
// Shared opcode/funct codes, FSM states and ALU ops for the MIPS-lite core.
// Optional MIPS_LITE_STATUS_FLAGS_EN adds the {V,Z,N} status register.
package mips_lite_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_BALN  = 6'h1B;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_BALRNV = 6'h17;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_SUB    = 6'h22;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_SLT    = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/mips_lite_alu.sv
// Shared combinational ALU of the MIPS-lite core.
// ovf reports signed overflow of add/sub only.
module mips_lite_alu
  import mips_lite_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] y,
  output logic            zero,
  output logic            ovf,
  output logic            neg
);

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    unique case (op)
      ALU_ADD: begin
        y   = a + b;
        ovf = (a[XLEN-1] == b[XLEN-1]) && (y[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        y   = a - b;
        ovf = (a[XLEN-1] != b[XLEN-1]) && (y[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = XLEN'($signed(a) < $signed(b));
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);
  assign neg  = y[XLEN-1];

endmodule

// File: rtl/mips_lite_multicycle_core.sv
// Multi-cycle MIPS-lite core with req/ack instruction and data ports.
// Define MIPS_LITE_STATUS_FLAGS_EN for {V,Z,N} flags, balrnv and baln.
module mips_lite_multicycle_core
  import mips_lite_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              LINK_REG = 31
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            retire,
  output logic            halted,
  output logic            illegal
);

  localparam int RW = $clog2(NREG);
  localparam logic [RW-1:0] LINK_IDX = RW'(LINK_REG);

  state_t state, state_n;
  logic run, ill_q;
  logic [31:0] ir;
  logic [XLEN-1:0] pc, npc, a, b, imm, alu_out, mdr;
  logic [XLEN-1:0] rf [NREG];

  logic [5:0] op, fn;
  logic [RW-1:0] rs, rt, rd, wb_idx;
  logic is_r_alu, is_jr, is_ori, is_lw, is_sw;
  logic is_beq, is_j, is_jal, is_halt;
  logic is_bal, bal_take, legal;
  alu_op_t alu_op;
  logic [XLEN-1:0] alu_b, alu_y, pc4, br_tgt, j_tgt, wb_data;
  logic alu_z, alu_v, alu_n;
  logic unused;

  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign rs = ir[21+:RW];
  assign rt = ir[16+:RW];
  assign rd = ir[11+:RW];

  assign is_r_alu = (op == OP_RTYPE) &&
    (fn == FN_ADD || fn == FN_SUB || fn == FN_AND ||
     fn == FN_OR || fn == FN_SLT);
  assign is_jr   = (op == OP_RTYPE) && (fn == FN_JR);
  assign is_ori  = (op == OP_ORI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
  assign is_halt = (op == OP_HALT);

`ifdef MIPS_LITE_STATUS_FLAGS_EN
  logic [2:0] flags, flags_x;
  logic is_balrnv, is_baln;
  assign is_balrnv = (op == OP_RTYPE) && (fn == FN_BALRNV);
  assign is_baln   = (op == OP_BALN);
  assign is_bal    = is_balrnv | is_baln;
  // Flags as they stood before this instruction
  assign bal_take  = (is_balrnv & flags[FLAG_V]) |
                     (is_baln & flags[FLAG_N]);
`else
  assign is_bal   = 1'b0;
  assign bal_take = 1'b0;
`endif

  assign legal = is_r_alu | is_jr | is_ori | is_lw | is_sw |
                 is_beq | is_j | is_jal | is_halt | is_bal;

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = b;
    unique case (1'b1)
      is_ori: begin
        alu_op = ALU_OR;
        alu_b  = imm;
      end
      is_lw, is_sw: alu_b = imm;
      is_beq: alu_op = ALU_SUB;
      is_r_alu: begin
        unique case (fn)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

  mips_lite_alu #(.XLEN(XLEN)) u_alu (
    .a    (a),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_z),
    .ovf  (alu_v),
    .neg  (alu_n)
  );

  assign pc4    = pc + XLEN'(4);
  assign br_tgt = pc4 + (imm << 2);
  assign j_tgt  = {pc4[XLEN-1:28], ir[25:0], 2'b00};

  always_comb begin
    wb_idx = LINK_IDX;
    unique case (1'b1)
      is_r_alu:       wb_idx = rd;
      is_ori, is_lw:  wb_idx = rt;
      default: ;
    endcase
  end

  assign wb_data = is_lw ? mdr : alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    retire   = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = run;
        if (run && imem_ack) state_n = S_DECODE;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        if (!legal || is_halt) state_n = S_HALTED;
        else if (is_lw || is_sw) state_n = S_MEM;
        else if (is_r_alu || is_ori || is_jal || bal_take)
          state_n = S_WB;
        else begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          retire  = is_sw;
          state_n = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_HALTED: ;
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      ill_q   <= 1'b0;
      ir      <= '0;
      pc      <= RESET_PC;
      npc     <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
`ifdef MIPS_LITE_STATUS_FLAGS_EN
      flags   <= '0;
      flags_x <= '0;
`endif
    end else begin
      // Hold requests off for one cycle after reset release
      run <= 1'b1;
      unique case (state)
        S_FETCH: if (run && imem_ack) ir <= imem_rdata;
        S_DECODE: begin
          a   <= rf[rs];
          b   <= rf[rt];
          imm <= is_ori ? XLEN'(ir[15:0])
                        : {{(XLEN-16){ir[15]}}, ir[15:0]};
        end
        S_EXEC: begin
          alu_out <= alu_y;
          npc     <= pc4;
`ifdef MIPS_LITE_STATUS_FLAGS_EN
          flags_x <= {alu_v, alu_z, alu_n};
`endif
          unique case (1'b1)
            is_beq: pc <= alu_z ? br_tgt : pc4;
            is_j:   pc <= j_tgt;
            is_jr:  pc <= a;
            is_jal: begin
              alu_out <= pc4;
              npc     <= j_tgt;
            end
`ifdef MIPS_LITE_STATUS_FLAGS_EN
            is_balrnv, is_baln: begin
              alu_out <= pc4;
              npc     <= is_balrnv ? a : j_tgt;
              if (!bal_take) pc <= pc4;
            end
`endif
            !legal: ill_q <= 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (is_sw) pc <= pc4;
            else       mdr <= dmem_rdata;
          end
        end
        S_WB: begin
          pc <= npc;
          if (wb_idx != '0) rf[wb_idx] <= wb_data;
`ifdef MIPS_LITE_STATUS_FLAGS_EN
          if (is_r_alu || is_ori) flags <= flags_x;
`endif
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = {pc[XLEN-1:2], 2'b00};
  assign dmem_we    = dmem_req & is_sw;
  assign dmem_addr  = {alu_out[XLEN-1:2], 2'b00};
  assign dmem_wdata = b;
  assign halted     = (state == S_HALTED);
  assign illegal    = ill_q;

  assign unused = ^{ir[10:6], pc[1:0], alu_v, alu_n};

endmodule

// File: tb/tb_mips_lite_multicycle_core.sv
// Directed bench for mips_lite_multicycle_core with an ISA-level model.
// Honours MIPS_LITE_STATUS_FLAGS_EN for the status-flag scenario.
module tb_mips_lite_multicycle_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic retire, halted, illegal;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

  always #5 clk = ~clk;

  mips_lite_multicycle_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .retire     (retire),
    .halted     (halted),
    .illegal    (illegal)
  );

  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  int imem_wait = 0, dmem_wait = 0;
  int icnt, dcnt;
  int wr_count = 0;

  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_rdata = dmem[dmem_addr[7:2]];
  assign imem_ack = imem_req && (icnt >= imem_wait);
  assign dmem_ack = dmem_req && (dcnt >= dmem_wait);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    end
  end

  always @(posedge clk)
    if (dmem_req && dmem_ack && dmem_we) wr_count <= wr_count + 1;

  int npass = 0, ntotal = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ISA-level reference model
  logic [31:0] mregs [32];
  logic [31:0] mpc;
  logic [2:0]  mfl;
  logic        mhalt, mill;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mpc = '0; mfl = '0; mhalt = 1'b0; mill = 1'b0;
  endtask

  task automatic m_wr(input int idx, input logic [31:0] v);
    if (idx != 0) mregs[idx] = v;
  endtask

  task automatic m_step(output int lat);
    logic [31:0] ins, va, vb, simm, pc4, r, npc, ea;
    logic [32:0] w;
    logic [5:0] op, fn;
    int rs, rt, rd;
    ins = imem[mpc[9:2]];
    op = ins[31:26]; fn = ins[5:0];
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    va = mregs[rs]; vb = mregs[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    pc4 = mpc + 4;
    npc = pc4;
    lat = 3 + imem_wait;
    case (op)
      6'h00: case (fn)
        6'h20: begin
          w = {va[31], va} + {vb[31], vb};
          m_wr(rd, w[31:0]); mfl = {w[32] != w[31], w[31:0] == 0, w[31]};
          lat++;
        end
        6'h22: begin
          w = {va[31], va} - {vb[31], vb};
          m_wr(rd, w[31:0]); mfl = {w[32] != w[31], w[31:0] == 0, w[31]};
          lat++;
        end
        6'h24: begin r = va & vb; m_wr(rd, r); mfl = {1'b0, r == 0, r[31]}; lat++; end
        6'h25: begin r = va | vb; m_wr(rd, r); mfl = {1'b0, r == 0, r[31]}; lat++; end
        6'h2A: begin
          r = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          m_wr(rd, r); mfl = {1'b0, r == 0, r[31]}; lat++;
        end
        6'h08: npc = va;
`ifdef MIPS_LITE_STATUS_FLAGS_EN
        6'h17: if (mfl[2]) begin m_wr(31, pc4); npc = va; lat++; end
`endif
        default: begin mhalt = 1'b1; mill = 1'b1; npc = mpc; lat++; end
      endcase
      6'h23: begin
        ea = va + simm;
        m_wr(rt, dmem[ea[7:2]]);
        lat = 5 + imem_wait + dmem_wait;
      end
      6'h2B: lat = 4 + imem_wait + dmem_wait;
      6'h04: if (va == vb) npc = pc4 + (simm << 2);
      6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin m_wr(31, pc4); npc = {pc4[31:28], ins[25:0], 2'b00}; lat++; end
      6'h0D: begin
        r = va | {16'h0, ins[15:0]};
        m_wr(rt, r); mfl = {1'b0, r == 0, r[31]}; lat++;
      end
`ifdef MIPS_LITE_STATUS_FLAGS_EN
      6'h1B: if (mfl[0]) begin
        m_wr(31, pc4); npc = {pc4[31:28], ins[25:0], 2'b00}; lat++;
      end
`endif
      6'h3F: begin mhalt = 1'b1; npc = mpc; lat++; end
      default: begin mhalt = 1'b1; mill = 1'b1; npc = mpc; lat++; end
    endcase
    mpc = npc;
  endtask

  int gap = 0, nret = 0, dreq4 = 0;
  bit pend = 0;
  int gaps [$];

  initial begin
    int lat, bad;
    logic [31:0] ins, ea;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        gap = 0;
      end else begin
        gap++;
        if (pend) begin
          check("pc", dut.pc, mpc);
          bad = 0;
          for (int i = 31; i >= 0; i--) if (dut.rf[i] !== mregs[i]) bad = i;
          check($sformatf("rf[%0d]", bad), dut.rf[bad], mregs[bad]);
          pend = 0;
        end
        if (mhalt) begin
          check("halted_quiet", {halted, imem_req, dmem_req, retire}, 32'h8);
        end else begin
          if (imem_req) check("imem_addr", imem_addr, mpc);
          if (dmem_req) begin
            ins = imem[mpc[9:2]];
            ea = mregs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
            check("dmem_addr", dmem_addr, {ea[31:2], 2'b00});
            check("dmem_we", dmem_we, ins[31:26] == 6'h2B);
            if (dmem_we) check("dmem_wdata", dmem_wdata, mregs[ins[20:16]]);
            if (dmem_addr == 32'd4) dreq4++;
          end
          if (retire) begin
            m_step(lat);
            check("latency", gap, lat);
            gaps.push_back(gap);
            nret++;
            gap = 0;
            pend = 1;
          end else if (halted) begin
            m_step(lat);
            check("halt_model", mhalt, 1);
            check("halt_latency", gap, lat);
            check("illegal", illegal, mill);
          end
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt,
                                        logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] t);
    return {op, t};
  endfunction

  task automatic begin_test();
    @(negedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 32'hFC00_0000;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    imem_wait = 0;
    dmem_wait = 0;
    m_reset();
    gaps.delete();
    nret = 0;
    dreq4 = 0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    check("halt_reached", halted, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c, w0;

    // 1: ori/add with zero-wait memories
    begin_test();
    #1;
    check("rst_outputs", {imem_req, dmem_req, dmem_we, retire, halted, illegal}, 0);
    check("rst_pc", dut.pc, 0);
    imem[0] = enc_i(6'h0D, 0, 1, 16'h00FF);
    imem[1] = enc_r(1, 1, 2, 6'h20);
    release_reset();
    wait_halt(100);
    check("t1_r2", dut.rf[2], 32'h1FE);
    check("t1_pc", dut.pc, 32'h8);
    check("t1_nret", nret, 2);
    check("t1_gap0", gaps[0], 4);
    check("t1_gap1", gaps[1], 4);

    // 2: lw with three data wait cycles
    begin_test();
    dmem[1] = 32'hDEAD_BEEF;
    dmem_wait = 3;
    imem[0] = enc_i(6'h23, 0, 3, 16'h0004);
    release_reset();
    wait_halt(100);
    check("t2_r3", dut.rf[3], 32'hDEAD_BEEF);
    check("t2_gap", gaps[0], 8);
    check("t2_req_hold", dreq4, 4);

    // 3a: beq to itself
    begin_test();
    imem[0] = enc_i(6'h04, 0, 0, 16'hFFFF);
    release_reset();
    for (int i = 0; i < 60 && nret < 3; i++) @(negedge clk);
    check("t3_nret", nret >= 3, 1);
    @(negedge clk);
    check("t3_pc", dut.pc, 0);
    check("t3_gap1", gaps[1], 3);
    check("t3_gap2", gaps[2], 3);

    // 3b: jal
    begin_test();
    imem[0] = enc_j(6'h03, 26'h40);
    release_reset();
    wait_halt(100);
    check("t3_r31", dut.rf[31], 32'h4);
    check("t3_jal_pc", dut.pc, 32'h100);

    // 4a: illegal opcode
    begin_test();
    imem[0] = 32'hF800_0000;
    release_reset();
    wait_halt(100);
    check("t4_ill", {halted, illegal}, 2'b11);
    c = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req) c++;
    end
    check("t4_noreq", c, 0);

    // 4b: HALT
    begin_test();
    release_reset();
    wait_halt(100);
    check("t4_halt", {halted, illegal}, 2'b10);

    // 5: reset during a store wait
    begin_test();
    dmem_wait = 6;
    imem[0] = enc_i(6'h0D, 0, 1, 16'h1234);
    imem[1] = enc_i(6'h2B, 0, 1, 16'h0008);
    release_reset();
    for (int i = 0; i < 50 && !dmem_req; i++) @(negedge clk);
    check("t5_mem_reached", dmem_req, 1);
    repeat (2) @(negedge clk);
    w0 = wr_count;
    #1 rst_n = 1'b0;
    #1;
    check("t5_req_drop", {dmem_req, imem_req}, 0);
    check("t5_pc_reset", dut.pc, 0);
    begin_test();
    release_reset();
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    check("t5_refetch", {imem_req, imem_addr}, {1'b1, 32'h0});
    wait_halt(100);
    check("t5_no_write", wr_count - w0, 0);
    check("t5_r1_clear", dut.rf[1], 0);

    // 6: add overflow then balrnv
    begin_test();
    dmem[0] = 32'h7FFF_FFFF;
    imem[0] = enc_i(6'h23, 0, 1, 16'h0000);
    imem[1] = enc_i(6'h0D, 0, 2, 16'h0001);
    imem[2] = enc_i(6'h0D, 0, 4, 16'h0080);
    imem[3] = enc_r(1, 2, 3, 6'h20);
    imem[4] = enc_r(4, 0, 0, 6'h17);
    release_reset();
    wait_halt(200);
    check("t6_r3", dut.rf[3], 32'h8000_0000);
`ifdef MIPS_LITE_STATUS_FLAGS_EN
    check("t6_r31", dut.rf[31], 32'd20);
    check("t6_pc", dut.pc, 32'h80);
    check("t6_ill", illegal, 0);
`else
    check("t6_r31", dut.rf[31], 32'd0);
    check("t6_pc", dut.pc, 32'd16);
    check("t6_ill", illegal, 1);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
